// File: rtl/mmcm_ps_ctrl.sv
// MMCM dynamic phase-shift initiator; PS_DONE_TIMEOUT_EN adds a sticky psdone timeout (err).
// psen one cycle after accept/psdone; req_ready low while busy, unlocked or in error.
module mmcm_ps_ctrl #(
  parameter int STEP_W          = 12,
  parameter int POS_W           = 10,
  parameter int STEPS_PER_CYCLE = 560,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                     psclk,
  input  logic                     resen,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic signed [STEP_W-1:0] req_steps,
  input  logic                     abort,
  input  logic                     locked,
  output logic                     psen,
  output logic                     psincdec,
  input  logic                     psdone,
  output logic                     busy,
  output logic [POS_W-1:0]         phase_pos,
  output logic                     done_pulse,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_DONE, ERROR} state_t;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(STEPS_PER_CYCLE - 1);

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              abort_q, abort_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [STEP_W-1:0] abs_steps;
  logic              accept;

`ifdef PS_DONE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Unsigned magnitude so the most negative request maps to 2^(STEP_W-1) steps.
  assign abs_steps = req_steps[STEP_W-1] ? $unsigned(-req_steps) : $unsigned(req_steps);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    abort_d = abort_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef PS_DONE_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif

    if (state_q != IDLE && abort) begin
      abort_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          dir_d = ~req_steps[STEP_W-1];
          rem_d = abs_steps;
          if (abs_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PULSE;
          end
        end
      end
      PULSE: begin
        state_d = WAIT_DONE;
`ifdef PS_DONE_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        if (psdone) begin
          if (dir_q) begin
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
          end else begin
            pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
          end
          rem_d = rem_q - 1'b1;
          if (rem_q == STEP_W'(1) || abort_q || abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else begin
            state_d = PULSE;
          end
        end
`ifdef PS_DONE_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Losing lock restarts the MMCM at phase 0; this overrides any psdone this cycle.
    if (!locked) begin
      state_d = IDLE;
      pos_d   = '0;
      rem_d   = '0;
      abort_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge psclk) begin
    if (!resen) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      abort_q <= 1'b0;
      pos_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PS_DONE_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      abort_q <= abort_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
`ifdef PS_DONE_TIMEOUT_EN
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
`else
      err_q   <= 1'b0;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE) & locked & ~err_q;
  assign psen       = (state_q == PULSE);
  assign psincdec   = (state_q != IDLE) & dir_q;
  assign busy       = (state_q != IDLE);
  assign phase_pos  = pos_q;
  assign done_pulse = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// Scoreboard bench: stimulus queues expected psen/done events, a monitor pops and compares them.
module tb_mmcm_ps_ctrl;

  localparam int STEP_W = 12;
  localparam int POS_W  = 10;
  localparam int SPC    = 560;

  logic                     psclk = 1'b0;
  logic                     resen = 1'b0;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic signed [STEP_W-1:0] req_steps = '0;
  logic                     abort = 1'b0;
  logic                     locked = 1'b1;
  logic                     psen;
  logic                     psincdec;
  logic                     psdone = 1'b0;
  logic                     busy;
  logic [POS_W-1:0]         phase_pos;
  logic                     done_pulse;
  logic                     err;

  mmcm_ps_ctrl #(
    .STEP_W(STEP_W), .POS_W(POS_W), .STEPS_PER_CYCLE(SPC), .TIMEOUT_CYCLES(64)
  ) dut (
    .psclk(psclk), .resen(resen), .req_valid(req_valid), .req_ready(req_ready),
    .req_steps(req_steps), .abort(abort), .locked(locked), .psen(psen),
    .psincdec(psincdec), .psdone(psdone), .busy(busy), .phase_pos(phase_pos),
    .done_pulse(done_pulse), .err(err)
  );

  always #5 psclk = ~psclk;

  typedef struct packed {
    logic             is_done;
    logic             dir;
    logic [POS_W-1:0] pos;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  psen_seen = 0;
  int  model_pos = 0;
  int  psdone_dly = 12;
  bit  model_en = 1'b1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int next_pos(input int p, input bit d);
    if (d) return (p == SPC - 1) ? 0 : p + 1;
    return (p == 0) ? SPC - 1 : p - 1;
  endfunction

  // MMCM stand-in: answers each psen with a one-cycle psdone psdone_dly cycles later.
  initial begin
    forever begin
      @(negedge psclk);
      if (psen === 1'b1 && model_en) begin
        repeat (psdone_dly) @(posedge psclk);
        #1 psdone = 1'b1;
        @(posedge psclk);
        #1 psdone = 1'b0;
      end
    end
  end

  // Monitor: every psen cycle and every done_pulse cycle must match the head of the queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge psclk);
      if (psen === 1'b1) begin
        psen_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL psen_unexpected: got psen=1 pos=%0d, want no psen", phase_pos);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done || psincdec !== e.dir || phase_pos !== e.pos) begin
            errors++;
            $display("FAIL psen_event: got psen dir=%0d pos=%0d, want done=%0d dir=%0d pos=%0d",
                     psincdec, phase_pos, e.is_done, e.dir, e.pos);
          end
        end
      end
      if (done_pulse === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done_pulse pos=%0d, want none", phase_pos);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done || phase_pos !== e.pos) begin
            errors++;
            $display("FAIL done_event: got done pos=%0d, want done=%0d pos=%0d",
                     phase_pos, e.is_done, e.pos);
          end
        end
      end
    end
  end

  task automatic push_exp(input bit d, input int n, input bit with_done);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.dir     = d;
      e.pos     = POS_W'(model_pos);
      exp_q.push_back(e);
      model_pos = next_pos(model_pos, d);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.dir     = 1'b0;
      e.pos     = POS_W'(model_pos);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_req(input int steps);
    bit ok;
    ok = 1'b0;
    @(posedge psclk);
    #1;
    req_valid = 1'b1;
    req_steps = STEP_W'(steps);
    for (int i = 0; i < 100; i++) begin
      @(negedge psclk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_accepted", int'(ok), 1);
    @(posedge psclk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge psclk);
      k++;
    end
    @(negedge psclk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_psen(input int target);
    for (int i = 0; i < 200; i++) begin
      @(negedge psclk);
      if (psen_seen >= target) break;
    end
    chk("psen_reached", int'(psen_seen >= target), 1);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge psclk);
    @(negedge psclk);
    chk("rst_psen", int'(psen), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pos", int'(phase_pos), 0);
    chk("rst_done", int'(done_pulse), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_psincdec", int'(psincdec), 0);
    @(posedge psclk);
    #1 resen = 1'b1;
    @(negedge psclk);
    chk("idle_ready", int'(req_ready), 1);

    // +3 from 0
    base = psen_seen;
    push_exp(1'b1, 3, 1'b1);
    issue_req(3);
    drain(200);
    chk("inc3_psen_count", psen_seen - base, 3);
    chk("inc3_pos", int'(phase_pos), 3);

    // Back to 1, then -3 wraps through 0 to 558
    push_exp(1'b0, 2, 1'b1);
    issue_req(-2);
    drain(200);
    chk("dec2_pos", int'(phase_pos), 1);
    push_exp(1'b0, 3, 1'b1);
    issue_req(-3);
    drain(200);
    chk("dec3_wrap_pos", int'(phase_pos), 558);

    // Zero request: done only, no psen
    base = psen_seen;
    push_exp(1'b1, 0, 1'b1);
    issue_req(0);
    drain(20);
    chk("zero_no_psen", psen_seen - base, 0);
    chk("zero_ready", int'(req_ready), 1);

    // +10 with abort during step 2 stops after 2 steps (558 -> 559 -> 0)
    base = psen_seen;
    push_exp(1'b1, 2, 1'b1);
    issue_req(10);
    wait_psen(base + 2);
    @(posedge psclk);
    #1 abort = 1'b1;
    @(posedge psclk);
    #1 abort = 1'b0;
    drain(200);
    chk("abort_psen_count", psen_seen - base, 2);
    chk("abort_pos", int'(phase_pos), 0);
    // Abort must not leak into the next request
    push_exp(1'b1, 2, 1'b1);
    issue_req(2);
    drain(200);
    chk("post_abort_pos", int'(phase_pos), 2);

    // +5 with lock lost after step 3: IDLE, pos 0, no done
    base = psen_seen;
    push_exp(1'b1, 4, 1'b0);
    issue_req(5);
    wait_psen(base + 4);
    @(posedge psclk);
    #1 locked = 1'b0;
    model_pos = 0;
    repeat (2) @(negedge psclk);
    chk("unlock_pos", int'(phase_pos), 0);
    chk("unlock_busy", int'(busy), 0);
    chk("unlock_ready", int'(req_ready), 0);
    repeat (20) @(negedge psclk);
    chk("unlock_pos_hold", int'(phase_pos), 0);
    chk("unlock_queue", exp_q.size(), 0);
    @(posedge psclk);
    #1 locked = 1'b1;
    @(negedge psclk);
    chk("relock_ready", int'(req_ready), 1);

    // Most negative request: 2048 decrements, 0 -> 192
    psdone_dly = 1;
    base = psen_seen;
    push_exp(1'b0, 2048, 1'b1);
    issue_req(-2048);
    drain(10000);
    chk("min_psen_count", psen_seen - base, 2048);
    chk("min_pos", int'(phase_pos), 192);
    psdone_dly = 12;

`ifdef PS_DONE_TIMEOUT_EN
    model_en = 1'b0;
    push_exp(1'b1, 1, 1'b0);
    model_pos = 192;
    issue_req(1);
    repeat (80) @(negedge psclk);
    chk("to_err", int'(err), 1);
    chk("to_busy", int'(busy), 1);
    chk("to_ready", int'(req_ready), 0);
    chk("to_pos", int'(phase_pos), 192);
    @(posedge psclk);
    #1 resen = 1'b0;
    repeat (2) @(negedge psclk);
    chk("to_rst_err", int'(err), 0);
    chk("to_rst_busy", int'(busy), 0);
    @(posedge psclk);
    #1 resen = 1'b1;
    model_en = 1'b1;
`endif

    repeat (5) @(negedge psclk);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
